iob_mem_responder: RTL



---
 rtl/iob_mem_responder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/iob_mem_responder.sv
// IOb native-bus target backed by a byte-strobed synchronous RAM.
// Adds optional wait states and external stall ahead of acceptance, then a fixed-latency read pipeline.
module iob_mem_responder #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MEM_ADDR_W  = 10,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned RD_LAT      = 1,
    parameter string       HEXFILE     = "none"
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                stall,
    output logic                ready,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata
);

    localparam int unsigned Depth = 2 ** MEM_ADDR_W;

    logic [DATA_W-1:0]     mem [Depth];
    logic [MEM_ADDR_W-1:0] mem_idx;
    logic                  acc;
    logic                  wr_acc;
    logic                  rd_acc;

    // Upper address bits and the byte offset are ignored, so addresses alias into the RAM.
    assign mem_idx = addr[MEM_ADDR_W+1:2];
    assign acc     = valid & ready;
    assign wr_acc  = acc & (|wstrb);
    assign rd_acc  = acc & ~(|wstrb);

    logic unused_addr;
    assign unused_addr = ^{addr[ADDR_W-1:MEM_ADDR_W+2], addr[1:0]};

    // Wait-state handling ahead of acceptance.
    if (WAIT_STATES == 0) begin : g_no_wait
        assign ready = valid & ~stall & ~rst;
    end else begin : g_wait
        typedef enum logic {StIdle, StWait} state_t;

        localparam logic [3:0] WsCnt = 4'(WAIT_STATES);

        state_t     state_q, state_d;
        logic [3:0] cnt_q, cnt_d;
        logic       ready_w;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= StIdle;
                cnt_q   <= 4'd0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // cnt counts cycles valid has been held and saturates at WsCnt; stall only masks ready.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            ready_w = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (valid) begin
                        state_d = StWait;
                        cnt_d   = 4'd1;
                    end
                end
                StWait: begin
                    if (!valid) begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                    end else begin
                        ready_w = (cnt_q == WsCnt) && !stall;
                        if (ready_w) begin
                            state_d = StIdle;
                            cnt_d   = 4'd0;
                        end else if (cnt_q != WsCnt) begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
            endcase
        end

        assign ready = ready_w;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (wstrb[i]) begin
                    mem[mem_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline; each data stage only loads with valid data so rdata holds between pulses.
    logic [RD_LAT-1:0] vld_q;
    logic [DATA_W-1:0] dat_q [RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                dat_q[0] <= mem[mem_idx];
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign rvalid = vld_q[RD_LAT-1];
    assign rdata  = dat_q[RD_LAT-1];

endmodule
